writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of the result bus, the registers and the output ports.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port D, input, WIDTH bits: the result to write back.
REQ-005 The block SHALL have the port DST, input, 3 bits: the destination code; 0-3 select t0-t3, 4 selects o0, 5 selects o1, 6-7 are null.
REQ-006 The block SHALL have the port WE, input, 1 bit: the write request is valid.
REQ-007 The block SHALL have the port RDY, output, 1 bit: the request can be accepted this cycle.
REQ-008 The block SHALL have the ports t0, t1, t2, t3, output, WIDTH bits each: the register contents that feed the operand selectors.
REQ-009 The block SHALL have the ports o0 and o1, output, WIDTH bits each: the output port data.
REQ-010 The block SHALL have the ports o0_vld and o1_vld, output, 1 bit each: the output port holds unconsumed data.
REQ-011 The block SHALL have the ports o0_ack and o1_ack, input, 1 bit each: the consumer takes oN this cycle.
REQ-012 The block SHALL have the port WCNT, output, 8 bits: the count of accepted writes.

Function
REQ-013 A write SHALL be accepted on a rising CLK edge where WE=1 and RDY=1; otherwise no state changes due to D/DST.
REQ-014 RDY SHALL be combinational: 0 only when DST=4 with o0_vld=1 and o0_ack=0, or DST=5 with o1_vld=1 and o1_ack=0; 1 in all other cases, independent of WE.
REQ-015 An accepted write with DST 0-3 SHALL load D into tDST; the new value is visible on tN in the cycle after the edge (1-cycle latency); the other registers are held.
REQ-016 An accepted write with DST 4 or 5 SHALL load D into oN and set oN_vld=1 at the same edge.
REQ-017 An edge with oN_vld=1, oN_ack=1 and no accepted write to oN SHALL clear oN_vld; oN data is held.
REQ-018 A simultaneous ack and accepted write to the same port SHALL keep oN_vld=1 and present the new D (ack-through, no bubble).
REQ-019 oN_ack while oN_vld=0 SHALL be ignored.
REQ-020 An accepted write with DST 6 or 7 SHALL change no t or o register, but SHALL still count in WCNT.
REQ-021 WCNT SHALL increment by 1 on every accepted write and wrap from 255 to 0.
REQ-022 A stall (RDY=0) on one output port SHALL NOT affect the other port's ack/vld behaviour.
REQ-023 D, DST and WE SHALL be held by the producer while WE=1 and RDY=0; the block requires no other behaviour in that case.

Reset
REQ-024 RST_N=0 SHALL immediately, without a clock, force t0-t3=0, o0=o1=0, o0_vld=o1_vld=0 and WCNT=0.
REQ-025 A write or ack coinciding with asserted reset SHALL be discarded; the first accept SHALL occur on the first rising edge after RST_N rises.
REQ-026 Reset asserted while an output port is full SHALL drop that data (vld=0), with no recovery.

Structure
REQ-027 A shared package SHALL hold the destination code constants DST_T0..DST_T3=0..3, DST_O0=4, DST_O1=5 and DST_NULL=6, and the default WIDTH; the operand-selector encoding SHALL use the same package.
REQ-028 One sub-module, out_port, SHALL implement the one-deep vld/ack buffer and be instantiated twice, for o0 and o1.
REQ-029 The t registers and WCNT SHALL live in the writeback top.

Verification
REQ-030 The bench SHALL check reset: after reset, all outputs are 0, including RDY=1 with DST=0.
REQ-031 The bench SHALL check register write: WE=1, DST=2, D=16'hBEEF for 1 cycle -> next cycle t2=BEEF, t0/t1/t3=0, WCNT=1.
REQ-032 The bench SHALL check port backpressure: write D=16'h0011 to DST=4 with o0_ack=0 -> o0=0011, o0_vld=1. Then write DST=4, D=0022 -> RDY=0 and o0 stays 0011. Then raise o0_ack -> RDY=1 and the next cycle shows o0=0022, o0_vld=1.
REQ-033 The bench SHALL check port independence: with o0 full and stalled, a write of D=16'h0055 to DST=5 -> accepted, o1=0055, o1_vld=1, o0 unchanged.
REQ-034 The bench SHALL check null writes and wrap: 256 accepted writes with DST=6 -> t/o registers unchanged, WCNT returns to 0; one more write -> WCNT=1.
REQ-035 The bench SHALL check reset mid-operation: o1_vld=1 and t3=16'h1234, then pulse RST_N low between clock edges -> all outputs 0 immediately, before the next CLK edge.

Source files
------------

// File: rtl/writeback_pkg.sv
// writeback_pkg: shared definitions for the writeback stage.
// Holds the destination / operand-selector encoding and the default data
// width, so the writeback block and the operand selectors decode the same
// codes.
package writeback_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Destination codes: 0-3 are the t registers, 4/5 the output ports,
    // 6 (and the unused 7) discard the data.
    typedef enum logic [2:0] {
        DST_T0   = 3'd0,
        DST_T1   = 3'd1,
        DST_T2   = 3'd2,
        DST_T3   = 3'd3,
        DST_O0   = 3'd4,
        DST_O1   = 3'd5,
        DST_NULL = 3'd6
    } dst_e;

    // True when the code addresses one of the t registers.
    function automatic logic is_treg(input logic [2:0] code);
        return (code[2] == 1'b0);
    endfunction

endpackage

// File: rtl/writeback_out_port.sv
// out_port: one-deep output buffer with valid/ack handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : an accepted write targets this port this cycle
//   d          : write data
//   ack        : consumer takes the buffered data this cycle
//   data, vld  : buffered data and "holds unconsumed data" flag
//   rdy        : a write to this port can be taken this cycle
module out_port #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] d,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             vld,
    output logic             rdy
);

    // A full buffer frees up in the same cycle it is acked, so a write can
    // flow straight through without a bubble.
    assign rdy = !(vld && !ack);

    // A write wins over an ack; an ack on an empty buffer just leaves vld low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            data <= d;
            vld  <= 1'b1;
        end else if (ack) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/writeback.sv
// writeback: result writeback stage.
// Writes result D to one of four t registers, to one of two handshaked
// output ports, or to nowhere (null), and counts accepted writes.
// Ports:
//   CLK, RST_N         : clock, asynchronous active-low reset
//   D, DST, WE         : write data, destination code, write request
//   RDY                : the request can be accepted this cycle
//   t0..t3             : t register contents
//   o0, o1             : output port data
//   o0_vld, o1_vld     : output port holds unconsumed data
//   o0_ack, o1_ack     : consumer takes the port data this cycle
//   WCNT               : count of accepted writes (wraps at 256)
module writeback
    import writeback_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       DST,
    input  logic             WE,
    output logic             RDY,
    output logic [WIDTH-1:0] t0,
    output logic [WIDTH-1:0] t1,
    output logic [WIDTH-1:0] t2,
    output logic [WIDTH-1:0] t3,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             o0_vld,
    output logic             o1_vld,
    input  logic             o0_ack,
    input  logic             o1_ack,
    output logic [7:0]       WCNT
);

    logic accept;
    logic o0_rdy;
    logic o1_rdy;
    logic o0_wr;
    logic o1_wr;

    // Only a write aimed at a stalled output port is held off; RDY does not
    // depend on WE so the producer can look at it before committing.
    always_comb begin
        RDY = 1'b1;
        case (DST)
            DST_O0:  RDY = o0_rdy;
            DST_O1:  RDY = o1_rdy;
            default: RDY = 1'b1;
        endcase
    end

    assign accept = WE && RDY;
    assign o0_wr  = accept && (DST == DST_O0);
    assign o1_wr  = accept && (DST == DST_O1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t0 <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
        end else if (accept && is_treg(DST)) begin
            case (DST[1:0])
                2'd0:    t0 <= D;
                2'd1:    t1 <= D;
                2'd2:    t2 <= D;
                default: t3 <= D;
            endcase
        end
    end

    // Null writes count too; the 8-bit counter wraps naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WCNT <= '0;
        end else if (accept) begin
            WCNT <= WCNT + 8'd1;
        end
    end

    out_port #(.WIDTH(WIDTH)) u_o0 (
        .clk   (CLK),
        .rst_n (RST_N),
        .wr    (o0_wr),
        .d     (D),
        .ack   (o0_ack),
        .data  (o0),
        .vld   (o0_vld),
        .rdy   (o0_rdy)
    );

    out_port #(.WIDTH(WIDTH)) u_o1 (
        .clk   (CLK),
        .rst_n (RST_N),
        .wr    (o1_wr),
        .d     (D),
        .ack   (o1_ack),
        .data  (o1),
        .vld   (o1_vld),
        .rdy   (o1_rdy)
    );

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed bench for writeback with a scoreboard.
// The stimulus process drives inputs and pushes the outputs it expects to
// see before the next clock edge; the monitor pops and compares on the
// falling edge.
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic [15:0] d;
    logic [2:0]  dst;
    logic        we;
    logic        rdy;
    logic [15:0] t0, t1, t2, t3, o0, o1;
    logic        o0_vld, o1_vld;
    logic        o0_ack, o1_ack;
    logic [7:0]  wcnt;

    typedef struct {
        string       name;
        logic [15:0] t0, t1, t2, t3, o0, o1;
        logic        v0, v1, rdy;
        logic [7:0]  wcnt;
    } exp_t;

    exp_t exp_q[$];

    // Hand-maintained expected state, updated by the stimulus before each check.
    logic [15:0] e_t0, e_t1, e_t2, e_t3, e_o0, e_o1;
    logic        e_v0, e_v1, e_rdy;
    logic [7:0]  e_wcnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit stim_done = 0;

    writeback #(.WIDTH(16)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .D      (d),
        .DST    (dst),
        .WE     (we),
        .RDY    (rdy),
        .t0     (t0),
        .t1     (t1),
        .t2     (t2),
        .t3     (t3),
        .o0     (o0),
        .o1     (o1),
        .o0_vld (o0_vld),
        .o1_vld (o1_vld),
        .o0_ack (o0_ack),
        .o1_ack (o1_ack),
        .WCNT   (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s.%s: got %h expected %h", name, field, got, want);
        end
    endtask

    // Monitor: compares every pending expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "t0",     t0,             e.t0);
            cmp(e.name, "t1",     t1,             e.t1);
            cmp(e.name, "t2",     t2,             e.t2);
            cmp(e.name, "t3",     t3,             e.t3);
            cmp(e.name, "o0",     o0,             e.o0);
            cmp(e.name, "o1",     o1,             e.o1);
            cmp(e.name, "o0_vld", {15'd0, o0_vld}, {15'd0, e.v0});
            cmp(e.name, "o1_vld", {15'd0, o1_vld}, {15'd0, e.v1});
            cmp(e.name, "rdy",    {15'd0, rdy},    {15'd0, e.rdy});
            cmp(e.name, "wcnt",   {8'd0, wcnt},    {8'd0, e.wcnt});
        end
    end

    task automatic applyStimulus(input logic w, input logic [2:0] ds,
                                 input logic [15:0] dv,
                                 input logic a0, input logic a1);
        we     = w;
        dst    = ds;
        d      = dv;
        o0_ack = a0;
        o1_ack = a1;
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        e.name = name;
        e.t0 = e_t0; e.t1 = e_t1; e.t2 = e_t2; e.t3 = e_t3;
        e.o0 = e_o0; e.o1 = e_o1;
        e.v0 = e_v0; e.v1 = e_v1; e.rdy = e_rdy;
        e.wcnt = e_wcnt;
        exp_q.push_back(e);
    endtask

    task automatic clear_expect();
        e_t0 = '0; e_t1 = '0; e_t2 = '0; e_t3 = '0;
        e_o0 = '0; e_o1 = '0;
        e_v0 = 1'b0; e_v1 = 1'b0; e_rdy = 1'b1;
        e_wcnt = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        clear_expect();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        checkOutput("reset");
        cycle();

        // Register write to t2.
        applyStimulus(1'b1, 3'd2, 16'hBEEF, 1'b0, 1'b0);
        checkOutput("t2_issue");
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_t2 = 16'hBEEF; e_wcnt = 8'd1;
        checkOutput("t2_write");
        cycle();

        // Backpressure on o0.
        applyStimulus(1'b1, 3'd4, 16'h0011, 1'b0, 1'b0);
        checkOutput("o0_issue");
        cycle();
        applyStimulus(1'b1, 3'd4, 16'h0022, 1'b0, 1'b0);
        e_o0 = 16'h0011; e_v0 = 1'b1; e_wcnt = 8'd2; e_rdy = 1'b0;
        checkOutput("o0_stall");
        cycle();
        checkOutput("o0_hold");
        cycle();
        applyStimulus(1'b1, 3'd4, 16'h0022, 1'b1, 1'b0);
        e_rdy = 1'b1;
        checkOutput("o0_ack_rdy");
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_o0 = 16'h0022; e_wcnt = 8'd3;
        checkOutput("o0_ackthru");
        cycle();

        // Drain o0, then ack on an empty port.
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        checkOutput("o0_drain_issue");
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0);
        e_v0 = 1'b0;
        checkOutput("o0_drained");
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        checkOutput("o0_ack_empty");
        cycle();

        // Port independence: o0 full and stalled, o1 still accepts.
        applyStimulus(1'b1, 3'd4, 16'h0033, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0, 1'b0);
        e_o0 = 16'h0033; e_v0 = 1'b1; e_wcnt = 8'd4; e_rdy = 1'b0;
        checkOutput("o0_full_rdy0");
        cycle();
        applyStimulus(1'b1, 3'd5, 16'h0055, 1'b0, 1'b0);
        e_rdy = 1'b1;
        checkOutput("o1_issue");
        cycle();
        applyStimulus(1'b0, 3'd5, 16'h0000, 1'b0, 1'b0);
        e_o1 = 16'h0055; e_v1 = 1'b1; e_wcnt = 8'd5; e_rdy = 1'b0;
        checkOutput("o1_indep");
        cycle();
        applyStimulus(1'b0, 3'd5, 16'h0000, 1'b0, 1'b1);
        e_rdy = 1'b1;
        checkOutput("o1_ack_rdy");
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_v1 = 1'b0;
        checkOutput("o1_drain_o0_held");
        cycle();

        // Refill o1 and load t3 for the later tests.
        applyStimulus(1'b1, 3'd5, 16'h0066, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_o1 = 16'h0066; e_v1 = 1'b1; e_t3 = 16'h1234; e_wcnt = 8'd7;
        checkOutput("preload");
        cycle();

        // Null writes: 249 more bring the count from 7 through 255 back to 0.
        for (int i = 0; i < 249; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 3'd6 : 3'd7, 16'hA5A5, 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_wcnt = 8'd0;
        checkOutput("null_wrap");
        cycle();
        applyStimulus(1'b1, 3'd6, 16'hFFFF, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        e_wcnt = 8'd1;
        checkOutput("null_plus1");
        cycle();

        // Reset mid-cycle with o1 full and t3 loaded; a write held across reset
        // must be discarded, then accepted on the first edge after release.
        applyStimulus(1'b1, 3'd0, 16'h9999, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        clear_expect();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        #2 rst_n = 1'b1;
        cycle();
        e_t0 = 16'h9999; e_wcnt = 8'd1;
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        checkOutput("first_accept");
        cycle();

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
